// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIF FFT sequencer.
// Default transform size, derived widths and the controller state type.
package fft_pkg;

   localparam int N_LOG2_DEF = 4;
   localparam int N_DEF      = 1 << N_LOG2_DEF;
   localparam int HALF_N_DEF = N_DEF / 2;
   localparam int ADDR_W_DEF = N_LOG2_DEF;
   localparam int TW_W_DEF   = N_LOG2_DEF - 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/fft_addr_dly.sv
// Fixed-depth shift register carrying read enables/addresses to the write side.
// Asynchronous clear so no stale write survives a reset.
module fft_addr_dly #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr [DEPTH];

   // Shift one slot per cycle; reset flushes every slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_dif_r2_ctrl.sv
// In-place radix-2 DIF FFT sequencer: butterfly read/twiddle/write addressing.
// Stages are separated by a drain so a stage never reads unwritten results.
module fft_dif_r2_ctrl
   import fft_pkg::*;
#(
   parameter int N_LOG2 = N_LOG2_DEF,
   parameter int RD_LAT = 1,
   parameter int BF_LAT = 1,
   localparam int STG_W = ($clog2(N_LOG2) < 1) ? 1 : $clog2(N_LOG2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [STG_W-1:0]  stage,
   output logic              rd_en,
   output logic [N_LOG2-1:0] rd_addr_a,
   output logic [N_LOG2-1:0] rd_addr_b,
   output logic [N_LOG2-2:0] tw_addr,
   output logic              wr_en,
   output logic [N_LOG2-1:0] wr_addr_a,
   output logic [N_LOG2-1:0] wr_addr_b
);

   localparam int N      = 1 << N_LOG2;
   localparam int HALF_N = N / 2;
   localparam int LAT    = RD_LAT + BF_LAT;
   localparam int K_W    = N_LOG2 - 1;
   localparam int D_W    = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int AG_W   = 3 * N_LOG2 - 1;
   localparam int DLY_W  = 1 + 2 * N_LOG2;

   state_t         state;
   logic [K_W-1:0] k;
   logic [D_W-1:0] dcnt;
   logic [DLY_W-1:0] dly_in;
   logic [DLY_W-1:0] dly_out;

   // Butterfly k of stage s -> {addr_a, addr_b, twiddle}
   function automatic logic [AG_W-1:0] gen(
      input logic [STG_W-1:0] s,
      input logic [K_W-1:0]   kk
   );
      logic [N_LOG2-1:0] span;
      logic [N_LOG2-1:0] pos;
      logic [N_LOG2-1:0] grp;
      logic [N_LOG2-1:0] a;
      logic [N_LOG2-1:0] b;
      logic [N_LOG2-1:0] twf;
      span = N_LOG2'(N >> (int'(s) + 1));
      pos  = {1'b0, kk} & (span - 1'b1);
      grp  = {1'b0, kk} >> (N_LOG2 - 1 - int'(s));
      // grp * 2 * span, span being a power of two
      a    = (grp << (N_LOG2 - int'(s))) + pos;
      b    = a + span;
      twf  = pos << s;
      return {a, b, twf[K_W-1:0]};
   endfunction

   // Control FSM with registered read-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         dcnt      <= '0;
         stage     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  stage <= '0;
                  k     <= '0;
                  rd_en <= 1'b1;
                  {rd_addr_a, rd_addr_b, tw_addr} <= gen('0, '0);
               end
            end
            RUN: begin
               if (k == K_W'(HALF_N - 1)) begin
                  state <= DRAIN;
                  dcnt  <= '0;
                  rd_en <= 1'b0;
                  {rd_addr_a, rd_addr_b, tw_addr} <= '0;
               end else begin
                  k <= k + 1'b1;
                  {rd_addr_a, rd_addr_b, tw_addr} <= gen(stage, k + 1'b1);
               end
            end
            DRAIN: begin
               if (dcnt == D_W'(LAT - 1)) begin
                  if (stage == STG_W'(N_LOG2 - 1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     stage <= stage + 1'b1;
                     k     <= '0;
                     rd_en <= 1'b1;
                     {rd_addr_a, rd_addr_b, tw_addr} <= gen(stage + 1'b1, '0);
                  end
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               stage <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dly_in = {rd_en, rd_addr_a, rd_addr_b};

   fft_addr_dly #(
      .WIDTH(DLY_W),
      .DEPTH(LAT)
   ) u_dly (
      .clk (clk),
      .rst (rst),
      .din (dly_in),
      .dout(dly_out)
   );

   assign {wr_en, wr_addr_a, wr_addr_b} = dly_out;

endmodule

// File: tb/tb_fft_dif_r2_ctrl.sv
// Self-checking bench for fft_dif_r2_ctrl: N=8 timing trace and N=16 FFT.
// Second instance drives a behavioural SRAM/butterfly and checks the result.
module tb_fft_dif_r2_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst3, start3, busy3, done3, rd_en3, wr_en3;
   logic [1:0] stage3, tw3;
   logic [2:0] ra3, rb3, wa3, wb3;

   logic       rst4, start4, busy4, done4, rd_en4, wr_en4;
   logic [1:0] stage4;
   logic [2:0] tw4;
   logic [3:0] ra4, rb4, wa4, wb4;

   fft_dif_r2_ctrl #(.N_LOG2(3), .RD_LAT(1), .BF_LAT(1)) u3 (
      .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .done(done3),
      .stage(stage3), .rd_en(rd_en3), .rd_addr_a(ra3), .rd_addr_b(rb3),
      .tw_addr(tw3), .wr_en(wr_en3), .wr_addr_a(wa3), .wr_addr_b(wb3)
   );

   fft_dif_r2_ctrl #(.N_LOG2(4), .RD_LAT(2), .BF_LAT(3)) u4 (
      .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4),
      .stage(stage4), .rd_en(rd_en4), .rd_addr_a(ra4), .rd_addr_b(rb4),
      .tw_addr(tw4), .wr_en(wr_en4), .wr_addr_a(wa4), .wr_addr_b(wb4)
   );

   typedef struct {
      int cyc;
      int stg;
      int a;
      int b;
      int tw;
   } rd_vec_t;

   typedef struct {
      int due;
      int a;
      int b;
   } wexp_t;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic rchk(input string name, input real act, input real exp);
      real d;
      checks++;
      d = act - exp;
      if (d < 0.0) d = -d;
      if (d > 1.0e-6) begin
         failures++;
         $display("FAIL %s: got %f expected %f", name, act, exp);
      end
   endtask

   function automatic int brev4(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = r | (1 << (3 - i));
      return r;
   endfunction

   rd_vec_t rv [12];
   wexp_t   wq [$];

   real mre [16];
   real mim [16];
   real xre [16];
   real xim [16];
   real q_gre [$];
   real q_gim [$];
   real q_hre [$];
   real q_him [$];
   int  q_tw [$];
   int  q_st [$];
   int  q_a [$];
   int  q_b [$];

   initial begin
      int  idx, dcyc, r2, seen, wdog;
      wexp_t e;
      real gre, gim, hre, him, dr, di, ang, cs, sn, sre, sim;
      int  tw, st;

      rv[0]  = '{1, 0, 0, 4, 0};  rv[1]  = '{2, 0, 1, 5, 1};
      rv[2]  = '{3, 0, 2, 6, 2};  rv[3]  = '{4, 0, 3, 7, 3};
      rv[4]  = '{7, 1, 0, 2, 0};  rv[5]  = '{8, 1, 1, 3, 2};
      rv[6]  = '{9, 1, 4, 6, 0};  rv[7]  = '{10, 1, 5, 7, 2};
      rv[8]  = '{13, 2, 0, 1, 0}; rv[9]  = '{14, 2, 2, 3, 0};
      rv[10] = '{15, 2, 4, 5, 0}; rv[11] = '{16, 2, 6, 7, 0};

      // reset state
      rst3 = 1'b1; rst4 = 1'b1; start3 = 1'b0; start4 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst busy", busy3, 0);
      chk("rst done", done3, 0);
      chk("rst rd_en", rd_en3, 0);
      chk("rst wr_en", wr_en3, 0);
      chk("rst stage", stage3, 0);
      chk("rst addrs", {ra3, rb3, tw3, wa3, wb3}, 0);
      chk("rst u4 outs", {busy4, rd_en4, wr_en4, ra4, wb4, tw4}, 0);
      rst3 = 1'b0; rst4 = 1'b0;

      // N=8 trace; stray start pulse while busy
      @(posedge clk); #1 start3 = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (c == 1) start3 = 1'b0;
         if (c == 5) start3 = 1'b1;
         if (c == 6) start3 = 1'b0;
         idx = -1;
         for (int i = 0; i < 12; i++) if (rv[i].cyc == c) idx = i;
         chk($sformatf("rd_en c%0d", c), rd_en3, idx >= 0);
         if (idx >= 0) begin
            chk($sformatf("rd_a c%0d", c), ra3, rv[idx].a);
            chk($sformatf("rd_b c%0d", c), rb3, rv[idx].b);
            chk($sformatf("tw c%0d", c), tw3, rv[idx].tw);
            chk($sformatf("stage c%0d", c), stage3, rv[idx].stg);
            wq.push_back('{c + 2, rv[idx].a, rv[idx].b});
         end
         if (wq.size() > 0 && wq[0].due == c) begin
            e = wq.pop_front();
            chk($sformatf("wr_en c%0d", c), wr_en3, 1);
            chk($sformatf("wr_a c%0d", c), wa3, e.a);
            chk($sformatf("wr_b c%0d", c), wb3, e.b);
         end else begin
            chk($sformatf("wr_en c%0d", c), wr_en3, 0);
         end
         chk($sformatf("done c%0d", c), done3, c == 19);
         chk($sformatf("busy c%0d", c), busy3, c >= 1 && c <= 19);
      end
      chk("wq drained", wq.size(), 0);

      // start held high: restart 2 cycles after done
      @(posedge clk); #1 start3 = 1'b1;
      dcyc = -1; r2 = -1;
      for (int c = 0; c < 60 && r2 < 0; c++) begin
         @(negedge clk);
         if (done3 && dcyc < 0) dcyc = c;
         else if (dcyc >= 0 && rd_en3) r2 = c;
      end
      start3 = 1'b0;
      chk("cont done cyc", dcyc, 19);
      chk("cont restart gap", r2 - dcyc, 2);
      seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
         @(negedge clk);
         if (done3) seen = 1;
      end
      chk("cont 2nd done seen", seen, 1);
      @(negedge clk);
      chk("cont busy after", busy3, 0);

      // reset mid-run in stage 1
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      seen = 0;
      for (int c = 0; c < 30 && seen == 0; c++) begin
         @(negedge clk);
         if (rd_en3 && stage3 == 2'd1) seen = 1;
      end
      chk("reach stage1", seen, 1);
      @(negedge clk);
      rst3 = 1'b1;
      #1;
      chk("midrst rd_en", rd_en3, 0);
      chk("midrst wr_en", wr_en3, 0);
      chk("midrst busy", busy3, 0);
      chk("midrst stage", stage3, 0);
      @(negedge clk); @(negedge clk);
      rst3 = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (wr_en3 || rd_en3 || busy3) seen++;
      end
      chk("post rst quiet", seen, 0);
      @(posedge clk); #1 start3 = 1'b1;
      dcyc = -1;
      for (int c = 0; c < 40 && dcyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) start3 = 1'b0;
         if (done3) dcyc = c;
      end
      chk("post rst done cyc", dcyc, 19);

      // N=16, LAT=5 with SRAM + butterfly model
      for (int i = 0; i < 16; i++) begin
         mre[i] = real'(int'($urandom_range(200)) - 100);
         mim[i] = real'(int'($urandom_range(200)) - 100);
         xre[i] = mre[i];
         xim[i] = mim[i];
      end
      @(posedge clk); #1 start4 = 1'b1;
      dcyc = -1;
      wdog = 0;
      for (int c = 0; c < 120 && dcyc < 0; c++) begin
         @(negedge clk);
         wdog = c;
         if (c == 1) start4 = 1'b0;
         if (wr_en4) begin
            if (q_a.size() == 0) begin
               chk("wr without rd", 1, 0);
            end else begin
               gre = q_gre.pop_front(); gim = q_gim.pop_front();
               hre = q_hre.pop_front(); him = q_him.pop_front();
               tw = q_tw.pop_front(); st = q_st.pop_front();
               chk($sformatf("u4 wr_a c%0d", c), wa4, q_a.pop_front());
               chk($sformatf("u4 wr_b c%0d", c), wb4, q_b.pop_front());
               if (rd_en4) chk($sformatf("hazard c%0d", c), stage4, st);
               dr = gre - hre; di = gim - him;
               ang = -2.0 * 3.14159265358979 * real'(tw) / 16.0;
               cs = $cos(ang); sn = $sin(ang);
               mre[wa4] = gre + hre; mim[wa4] = gim + him;
               mre[wb4] = dr * cs - di * sn;
               mim[wb4] = dr * sn + di * cs;
            end
         end
         if (rd_en4) begin
            q_gre.push_back(mre[ra4]); q_gim.push_back(mim[ra4]);
            q_hre.push_back(mre[rb4]); q_him.push_back(mim[rb4]);
            q_tw.push_back(int'(tw4)); q_st.push_back(int'(stage4));
            q_a.push_back(int'(ra4)); q_b.push_back(int'(rb4));
         end
         if (done4) dcyc = c;
      end
      chk("u4 done cyc", dcyc, 53);
      chk("u4 wdog", wdog < 119, 1);
      chk("u4 pipe empty", q_a.size(), 0);
      for (int kk = 0; kk < 16; kk++) begin
         sre = 0.0; sim = 0.0;
         for (int n = 0; n < 16; n++) begin
            ang = -2.0 * 3.14159265358979 * real'((n * kk) % 16) / 16.0;
            sre = sre + xre[n] * $cos(ang) - xim[n] * $sin(ang);
            sim = sim + xre[n] * $sin(ang) + xim[n] * $cos(ang);
         end
         rchk($sformatf("X%0d re", kk), mre[brev4(kk)], sre);
         rchk($sformatf("X%0d im", kk), mim[brev4(kk)], sim);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_dif_r2_ctrl.md
Name: fft_dif_r2_ctrl

Overview:
Sequencer for the in-place radix-2 DIF FFT core: one butterfly unit, one dual-port SRAM holding N = 2^N_LOG2 complex points. Per stage it issues N/2 butterfly read-address pairs, twiddle indices and the matching delayed write-back address pairs, so results overwrite their source locations. It sits between the top-level start/done interface and the memory/butterfly datapath, draining the pipeline between stages to avoid read-after-write hazards.

Parameters:
N_LOG2, 4, log2 of FFT length (N = 2^N_LOG2; legal 2..10)
RD_LAT, 1, SRAM read latency in cycles (read address to data valid at butterfly input)
BF_LAT, 1, butterfly + twiddle-multiply pipeline latency in cycles (≥0)
LAT = RD_LAT + BF_LAT, derived: cycles from rd_en to the corresponding wr_en

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin transform; sampled only in IDLE
busy  out  1  high from cycle after start accepted until done pulse cycle inclusive
done  out  1  single-cycle pulse, transform complete
stage  out  max(1,$clog2(N_LOG2))  current read stage index
rd_en  out  1  read both SRAM ports this cycle
rd_addr_a  out  N_LOG2  upper-wing (G) read address
rd_addr_b  out  N_LOG2  lower-wing (H) read address
tw_addr  out  N_LOG2-1  twiddle ROM index W_N^tw, aligned with rd_en
wr_en  out  1  write both SRAM ports this cycle
wr_addr_a  out  N_LOG2  write address for T = G+H
wr_addr_b  out  N_LOG2  write address for Y·W = (G−H)·W

Behaviour:
- Reset (async assert, any time incl. mid-transform): state IDLE; busy, done, rd_en, wr_en = 0; all addresses, tw_addr, stage = 0; delay line flushed (no write may issue after reset release). Partial SRAM contents not restored.
- FSM: IDLE -> RUN on start=1. RUN: butterfly counter k = 0..N/2−1, one pair per cycle, rd_en=1. After k=N/2−1 -> DRAIN. DRAIN: LAT cycles, rd_en=0, delayed writes complete. End of DRAIN: if stage < N_LOG2−1 then stage++, k=0, -> RUN; else -> DONE. DONE: done=1 one cycle, -> IDLE.
- Address generation for stage s, span = N >> (s+1): pos = k & (span−1); grp = k >> (N_LOG2−1−s); rd_addr_a = grp·2·span + pos; rd_addr_b = rd_addr_a + span; tw_addr = pos << s. All registered outputs.
- Write path: {rd_en, rd_addr_a, rd_addr_b} pass through LAT-stage shift register; wr_en/wr_addr_* = its output. LAT=0 not legal (RD_LAT ≥1).
- Hazard rule: first read of stage s+1 occurs cycle after last write of stage s; rd_en and wr_en of different stages never overlap, same-stage overlap allowed (disjoint addresses).
- Timing: start high in cycle 0 -> first rd_en cycle 1; each stage occupies N/2 + LAT cycles; done in cycle N_LOG2·(N/2+LAT) + 1.
- start while busy ignored; start held high in DONE cycle ignored, re-sampled in IDLE next cycle.
- Output ordering is natural in, bit-reversed out (DIF); controller does no reordering.

Decomposition:
- Shared package fft_pkg: N_LOG2 default, derived N, HALF_N, address/twiddle widths, FSM state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: fft_addr_dly (parameterised width/depth shift register with async clear) for the write-address delay line.

Test Plan:
- Reset: assert rst mid-RUN at stage 1 -> same cycle rd_en=wr_en=busy=0; no wr_en for 10 cycles after release; next start runs full transform.
- N_LOG2=3, RD_LAT=1, BF_LAT=1: start cycle 0 -> stage0 reads cycles 1–4 pairs (0,4),(1,5),(2,6),(3,7) tw 0,1,2,3; writes same pairs cycles 3–6.
- Same config: stage1 reads cycles 7–10 pairs (0,2),(1,3),(4,6),(5,7) tw 0,2,0,2; stage2 reads 13–16 pairs (0,1),(2,3),(4,5),(6,7) tw 0; last write cycle 18, done cycle 19, busy low cycle 20.
- Start held high continuously -> second transform's first rd_en exactly 2 cycles after done; start pulses while busy produce no extra transform.
- Scoreboard N_LOG2=4, RD_LAT=2, BF_LAT=3 with behavioural SRAM + butterfly model: random input -> memory equals bit-reversed reference FFT; assert no cycle with rd_en & wr_en from different stages.
